// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/MEM memory-port arbiter: FSM state, access owner, memory func3 codes.
package mem_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } arb_owner_e;

  localparam int F3_W = 3;
  typedef logic [F3_W-1:0] func3_t;

  // Size/sign codes interpreted by the memory itself.
  localparam func3_t F3_LB  = 3'b000;
  localparam func3_t F3_LH  = 3'b001;
  localparam func3_t F3_LW  = 3'b010;
  localparam func3_t F3_LBU = 3'b100;
  localparam func3_t F3_LHU = 3'b101;
  localparam func3_t F3_SB  = 3'b000;
  localparam func3_t F3_SH  = 3'b001;
  localparam func3_t F3_SW  = 3'b010;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch and data request/response channels plus the shared memory command port.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_stall;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  func3_t            d_func3;
  logic              d_gnt;
  logic              d_stall;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  func3_t            mem_func3;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter view.
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_func3, mem_rdata,
    output if_gnt, if_stall, if_rvalid, if_rdata,
    output d_gnt, d_stall, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_func3
  );

  // Core pipeline and memory view.
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_func3, mem_rdata,
    input  if_gnt, if_stall, if_rvalid, if_rdata,
    input  d_gnt, d_stall, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_func3
  );

endinterface

// File: rtl/mem_port_arbiter_lat_cnt.sv
// Loadable down-counter tracking memory latency; done marks the cycle read data is valid.
module arb_lat_cnt #(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic done
);

  localparam int CW = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(MEM_LAT);

  logic [CW-1:0] cnt_r;

  // Latency count: reload on start, otherwise count down to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (start) begin
      cnt_r <= LOAD_VAL;
    end else if (cnt_r != {CW{1'b0}}) begin
      cnt_r <= cnt_r - CW'(1'b1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign done = (cnt_r == CW'(1'b1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and MEM-stage data accesses.
// Optional fetch starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  if (MEM_LAT < 1 || STARVE_MAX < 0) begin : g_bad_cfg
    $error("mem_port_arbiter: MEM_LAT must be >= 1 and STARVE_MAX >= 0");
  end

  arb_state_e        state_r;
  arb_state_e        state_n_s;
  arb_owner_e        owner_r;
  arb_owner_e        owner_n_s;
  logic              d_we_r;

  logic              done_s;
  logic              free_s;
  logic              force_if_s;
  logic              if_gnt_s;
  logic              d_gnt_s;
  logic              start_s;

  logic              mem_en_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [DATA_W-1:0] mem_wdata_s;
  func3_t            mem_func3_s;

  logic              if_rvalid_r;
  logic [DATA_W-1:0] if_rdata_r;
  logic              d_rvalid_r;
  logic [DATA_W-1:0] d_rdata_r;

  arb_lat_cnt #(.MEM_LAT(MEM_LAT)) u_lat_cnt (
    .clk   (clk),
    .rst   (rst),
    .start (start_s),
    .done  (done_s)
  );

  // The memory is free in the cycle its read data is valid, so grants can chain.
  assign free_s  = (state_r == ST_IDLE) | done_s;
  assign start_s = if_gnt_s | d_gnt_s;

`ifdef ARB_STARVE_GUARD_EN
  localparam int SCW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SCW-1:0] STARVE_LIM = SCW'(STARVE_MAX);

  logic [SCW-1:0] starve_cnt_r;

  // Starvation counter: counts denied fetch cycles, saturating, cleared by a fetch grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_r <= {SCW{1'b0}};
    end else if (if_gnt_s) begin
      starve_cnt_r <= {SCW{1'b0}};
    end else if (bus.if_req && (starve_cnt_r != STARVE_LIM)) begin
      starve_cnt_r <= starve_cnt_r + SCW'(1'b1);
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

  assign force_if_s = bus.if_req & (starve_cnt_r == STARVE_LIM);
`else
  assign force_if_s = 1'b0;
`endif

  // Grant selection: data first unless fetch has starved; nothing granted during reset.
  always_comb begin
    if_gnt_s = 1'b0;
    d_gnt_s  = 1'b0;
    if (rst || !free_s) begin
      if_gnt_s = 1'b0;
    end else if (bus.d_req && !force_if_s) begin
      d_gnt_s = 1'b1;
    end else if (bus.if_req) begin
      if_gnt_s = 1'b1;
    end else begin
      d_gnt_s = 1'b0;
    end
  end

  // Memory command mux driven by the granted requester.
  always_comb begin
    mem_en_s    = 1'b0;
    mem_we_s    = 1'b0;
    mem_addr_s  = {ADDR_W{1'b0}};
    mem_wdata_s = {DATA_W{1'b0}};
    mem_func3_s = 3'b000;
    if (d_gnt_s) begin
      mem_en_s    = 1'b1;
      mem_we_s    = bus.d_we;
      mem_addr_s  = bus.d_addr;
      mem_wdata_s = bus.d_wdata;
      mem_func3_s = bus.d_func3;
    end else if (if_gnt_s) begin
      mem_en_s    = 1'b1;
      mem_addr_s  = bus.if_addr;
      mem_func3_s = F3_LW;
    end else begin
      mem_en_s = 1'b0;
    end
  end

  // Next state and owner of the outstanding access.
  always_comb begin
    state_n_s = state_r;
    owner_n_s = owner_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_n_s = ST_WAIT;
          owner_n_s = d_gnt_s ? OWN_D : OWN_IF;
        end else begin
          state_n_s = ST_IDLE;
          owner_n_s = OWN_NONE;
        end
      end
      ST_WAIT: begin
        if (start_s) begin
          state_n_s = ST_WAIT;
          owner_n_s = d_gnt_s ? OWN_D : OWN_IF;
        end else if (done_s) begin
          state_n_s = ST_IDLE;
          owner_n_s = OWN_NONE;
        end else begin
          state_n_s = ST_WAIT;
          owner_n_s = owner_r;
        end
      end
      default: begin
        state_n_s = ST_IDLE;
        owner_n_s = OWN_NONE;
      end
    endcase
  end

  // State, owner and store flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      owner_r <= OWN_NONE;
      d_we_r  <= 1'b0;
    end else begin
      state_r <= state_n_s;
      owner_r <= owner_n_s;
      d_we_r  <= d_gnt_s ? bus.d_we : d_we_r;
    end
  end

  // Response registers: route the completed access to its owner only; stores return zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_rvalid_r <= 1'b0;
      if_rdata_r  <= {DATA_W{1'b0}};
      d_rvalid_r  <= 1'b0;
      d_rdata_r   <= {DATA_W{1'b0}};
    end else begin
      if_rvalid_r <= done_s && (owner_r == OWN_IF);
      if_rdata_r  <= (done_s && (owner_r == OWN_IF)) ? bus.mem_rdata : {DATA_W{1'b0}};
      d_rvalid_r  <= done_s && (owner_r == OWN_D);
      d_rdata_r   <= (done_s && (owner_r == OWN_D) && !d_we_r) ? bus.mem_rdata : {DATA_W{1'b0}};
    end
  end

  assign bus.if_gnt    = if_gnt_s;
  assign bus.if_stall  = bus.if_req & ~if_gnt_s;
  assign bus.if_rvalid = if_rvalid_r;
  assign bus.if_rdata  = if_rdata_r;
  assign bus.d_gnt     = d_gnt_s;
  assign bus.d_stall   = bus.d_req & ~d_gnt_s;
  assign bus.d_rvalid  = d_rvalid_r;
  assign bus.d_rdata   = d_rdata_r;
  assign bus.mem_en    = mem_en_s;
  assign bus.mem_we    = mem_we_s;
  assign bus.mem_addr  = mem_addr_s;
  assign bus.mem_wdata = mem_wdata_s;
  assign bus.mem_func3 = mem_func3_s;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: one MEM_LAT=1 and one MEM_LAT=3 instance.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  exp_t q_if1[$];
  exp_t q_d1[$];
  exp_t q_if3[$];
  exp_t q_d3[$];
  exp_t mon_e;

  logic [31:0] m1[64];
  logic [31:0] m3[64];
  logic [31:0] p1, p3a, p3b, p3c;

  mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus1 ();
  mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus3 ();

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(3)) u_dut1 (
    .clk (clk), .rst (rst), .bus (bus1)
  );
  mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(3)) u_dut3 (
    .clk (clk), .rst (rst), .bus (bus3)
  );

  assign bus1.mem_rdata = p1;
  assign bus3.mem_rdata = p3c;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  // Word-addressed memories; read data appears exactly MEM_LAT cycles after mem_en.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) begin
        m1[i] <= init_word(i);
        m3[i] <= init_word(i);
      end
      p1 <= 32'hBAD0_BAD0; p3a <= 32'hBAD0_BAD0; p3b <= 32'hBAD0_BAD0; p3c <= 32'hBAD0_BAD0;
    end else begin
      p1  <= 32'hBAD0_BAD0;
      p3a <= 32'hBAD0_BAD0;
      if (bus1.mem_en === 1'b1) begin
        if (bus1.mem_we) m1[bus1.mem_addr[7:2]] <= bus1.mem_wdata;
        else p1 <= m1[bus1.mem_addr[7:2]];
      end
      if (bus3.mem_en === 1'b1) begin
        if (bus3.mem_we) m3[bus3.mem_addr[7:2]] <= bus3.mem_wdata;
        else p3a <= m3[bus3.mem_addr[7:2]];
      end
      p3b <= p3a;
      p3c <= p3b;
    end
  end

  // Response monitor: every rvalid pops one expectation; idle cycles must carry zero data.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (bus1.if_rvalid === 1'b1) begin
        if (q_if1.size() == 0) begin errors++; $display("FAIL if1_resp unexpected cyc=%0d data=%h", cyc, bus1.if_rdata); end
        else begin
          mon_e = q_if1.pop_front();
          if (bus1.if_rdata !== mon_e.data || cyc != mon_e.cyc) begin errors++;
            $display("FAIL if1_resp cyc=%0d data=%h expected cyc=%0d data=%h", cyc, bus1.if_rdata, mon_e.cyc, mon_e.data); end
        end
      end else if (bus1.if_rvalid !== 1'b0 || bus1.if_rdata !== 32'h0) begin
        errors++; $display("FAIL if1_idle cyc=%0d rvalid=%b data=%h expected 0/0", cyc, bus1.if_rvalid, bus1.if_rdata);
      end
      checks++;
      if (bus1.d_rvalid === 1'b1) begin
        if (q_d1.size() == 0) begin errors++; $display("FAIL d1_resp unexpected cyc=%0d data=%h", cyc, bus1.d_rdata); end
        else begin
          mon_e = q_d1.pop_front();
          if (bus1.d_rdata !== mon_e.data || cyc != mon_e.cyc) begin errors++;
            $display("FAIL d1_resp cyc=%0d data=%h expected cyc=%0d data=%h", cyc, bus1.d_rdata, mon_e.cyc, mon_e.data); end
        end
      end else if (bus1.d_rvalid !== 1'b0 || bus1.d_rdata !== 32'h0) begin
        errors++; $display("FAIL d1_idle cyc=%0d rvalid=%b data=%h expected 0/0", cyc, bus1.d_rvalid, bus1.d_rdata);
      end
      checks++;
      if (bus3.if_rvalid === 1'b1) begin
        if (q_if3.size() == 0) begin errors++; $display("FAIL if3_resp unexpected cyc=%0d data=%h", cyc, bus3.if_rdata); end
        else begin
          mon_e = q_if3.pop_front();
          if (bus3.if_rdata !== mon_e.data || cyc != mon_e.cyc) begin errors++;
            $display("FAIL if3_resp cyc=%0d data=%h expected cyc=%0d data=%h", cyc, bus3.if_rdata, mon_e.cyc, mon_e.data); end
        end
      end else if (bus3.if_rvalid !== 1'b0 || bus3.if_rdata !== 32'h0) begin
        errors++; $display("FAIL if3_idle cyc=%0d rvalid=%b data=%h expected 0/0", cyc, bus3.if_rvalid, bus3.if_rdata);
      end
      checks++;
      if (bus3.d_rvalid === 1'b1) begin
        if (q_d3.size() == 0) begin errors++; $display("FAIL d3_resp unexpected cyc=%0d data=%h", cyc, bus3.d_rdata); end
        else begin
          mon_e = q_d3.pop_front();
          if (bus3.d_rdata !== mon_e.data || cyc != mon_e.cyc) begin errors++;
            $display("FAIL d3_resp cyc=%0d data=%h expected cyc=%0d data=%h", cyc, bus3.d_rdata, mon_e.cyc, mon_e.data); end
        end
      end else if (bus3.d_rvalid !== 1'b0 || bus3.d_rdata !== 32'h0) begin
        errors++; $display("FAIL d3_idle cyc=%0d rvalid=%b data=%h expected 0/0", cyc, bus3.d_rvalid, bus3.d_rdata);
      end
    end
  end

  task automatic drive_idle();
    bus1.if_req = 1'b0; bus1.if_addr = 8'h00; bus1.d_req = 1'b0; bus1.d_we = 1'b0;
    bus1.d_addr = 8'h00; bus1.d_wdata = 32'h0; bus1.d_func3 = 3'b000;
    bus3.if_req = 1'b0; bus3.if_addr = 8'h00; bus3.d_req = 1'b0; bus3.d_we = 1'b0;
    bus3.d_addr = 8'h00; bus3.d_wdata = 32'h0; bus3.d_func3 = 3'b000;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    bus1.d_req = 1'b1; bus1.d_addr = 8'h40; bus1.d_func3 = F3_LW;
    bus3.if_req = 1'b1;
    @(negedge clk);
    checks++;
    if (bus1.d_gnt !== 1'b0 || bus1.mem_en !== 1'b0 || bus3.if_gnt !== 1'b0 || bus3.mem_en !== 1'b0) begin
      errors++; $display("FAIL reset_gate d_gnt=%b mem_en=%b if_gnt3=%b mem_en3=%b expected 0", bus1.d_gnt, bus1.mem_en, bus3.if_gnt, bus3.mem_en);
    end
    checks++;
    if ({bus1.if_rvalid, bus1.d_rvalid, bus1.if_rdata, bus1.d_rdata, bus1.mem_we, bus1.mem_addr, bus1.mem_wdata, bus1.mem_func3} !== 110'h0) begin
      errors++; $display("FAIL reset_out1 if_rdata=%h d_rdata=%h mem_addr=%h expected 0", bus1.if_rdata, bus1.d_rdata, bus1.mem_addr);
    end
    checks++;
    if ({bus3.if_rvalid, bus3.d_rvalid, bus3.if_rdata, bus3.d_rdata, bus3.mem_we, bus3.mem_addr, bus3.mem_wdata, bus3.mem_func3} !== 110'h0) begin
      errors++; $display("FAIL reset_out3 if_rdata=%h d_rdata=%h mem_addr=%h expected 0", bus3.if_rdata, bus3.d_rdata, bus3.mem_addr);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive_idle();
    mon_en = 1'b1;
  endtask

  task automatic test_fetch_only();
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      bus1.if_req = 1'b1;
      bus1.if_addr = 8'(4 * k);
      @(negedge clk);
      checks++;
      if (bus1.if_gnt !== 1'b1 || bus1.if_stall !== 1'b0 || bus1.mem_addr !== 8'(4 * k)) begin
        errors++; $display("FAIL fetch_gnt k=%0d gnt=%b stall=%b addr=%h expected 1/0/%h", k, bus1.if_gnt, bus1.if_stall, bus1.mem_addr, 8'(4 * k));
      end
      q_if1.push_back('{cyc + 2, init_word(k)});
      @(posedge clk);
      #1;
    end
    drive_idle();
    repeat (5) @(negedge clk);
    checks++;
    if (q_if1.size() != 0) begin errors++; $display("FAIL fetch_drain pending=%0d expected 0", q_if1.size()); end
  endtask

  task automatic test_collision();
    int c;
    @(posedge clk);
    #1;
    bus1.if_req = 1'b1; bus1.if_addr = 8'h20;
    bus1.d_req = 1'b1; bus1.d_we = 1'b0; bus1.d_addr = 8'h40; bus1.d_func3 = F3_LW;
    @(negedge clk);
    c = cyc;
    checks++;
    if (bus1.d_gnt !== 1'b1 || bus1.if_gnt !== 1'b0 || bus1.if_stall !== 1'b1 || bus1.d_stall !== 1'b0 || bus1.mem_addr !== 8'h40) begin
      errors++; $display("FAIL collide_first d_gnt=%b if_gnt=%b if_stall=%b addr=%h expected 1/0/1/40", bus1.d_gnt, bus1.if_gnt, bus1.if_stall, bus1.mem_addr);
    end
    q_d1.push_back('{c + 2, init_word(16)});
    @(posedge clk);
    #1;
    bus1.d_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus1.if_gnt !== 1'b1 || bus1.d_gnt !== 1'b0 || bus1.if_stall !== 1'b0 || bus1.mem_addr !== 8'h20) begin
      errors++; $display("FAIL collide_fetch if_gnt=%b d_gnt=%b addr=%h expected 1/0/20", bus1.if_gnt, bus1.d_gnt, bus1.mem_addr);
    end
    q_if1.push_back('{c + 3, init_word(8)});
    @(posedge clk);
    #1;
    drive_idle();
    repeat (5) @(negedge clk);
    checks++;
    if (q_if1.size() != 0 || q_d1.size() != 0) begin errors++; $display("FAIL collide_drain pending=%0d expected 0", q_if1.size() + q_d1.size()); end
  endtask

  task automatic test_starvation();
    logic exp_if;
    @(posedge clk);
    #1;
    bus1.if_req = 1'b1; bus1.if_addr = 8'h0C;
    bus1.d_req = 1'b1; bus1.d_we = 1'b0; bus1.d_addr = 8'h44; bus1.d_func3 = F3_LW;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
`ifdef ARB_STARVE_GUARD_EN
      exp_if = (i == 3);
`else
      exp_if = 1'b0;
`endif
      checks++;
      if (bus1.if_gnt !== exp_if || bus1.d_gnt !== ~exp_if) begin
        errors++; $display("FAIL starve_gnt i=%0d if_gnt=%b d_gnt=%b expected %b/%b", i, bus1.if_gnt, bus1.d_gnt, exp_if, ~exp_if);
      end
      if (exp_if) q_if1.push_back('{cyc + 2, init_word(3)});
      else q_d1.push_back('{cyc + 2, init_word(17)});
    end
    @(posedge clk);
    #1;
    drive_idle();
    repeat (5) @(negedge clk);
    checks++;
    if (q_if1.size() != 0 || q_d1.size() != 0) begin errors++; $display("FAIL starve_drain pending=%0d expected 0", q_if1.size() + q_d1.size()); end
  endtask

  task automatic test_store_load_lat3();
    int c;
    @(posedge clk);
    #1;
    bus3.d_req = 1'b1; bus3.d_we = 1'b1; bus3.d_addr = 8'h10; bus3.d_wdata = 32'hDEAD_BEEF; bus3.d_func3 = F3_SW;
    @(negedge clk);
    c = cyc;
    checks++;
    if (bus3.d_gnt !== 1'b1 || bus3.mem_we !== 1'b1 || bus3.mem_wdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL lat3_store_gnt gnt=%b we=%b wdata=%h expected 1/1/deadbeef", bus3.d_gnt, bus3.mem_we, bus3.mem_wdata);
    end
    q_d3.push_back('{c + 4, 32'h0});
    @(posedge clk);
    #1;
    bus3.d_we = 1'b0; bus3.d_wdata = 32'h0; bus3.d_func3 = F3_LW;
    bus3.if_req = 1'b1; bus3.if_addr = 8'h00;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (bus3.d_gnt !== 1'b0 || bus3.if_gnt !== 1'b0 || bus3.d_stall !== 1'b1 || bus3.if_stall !== 1'b1 || bus3.mem_en !== 1'b0) begin
        errors++; $display("FAIL lat3_busy i=%0d d_gnt=%b if_gnt=%b d_stall=%b if_stall=%b expected 0/0/1/1", i, bus3.d_gnt, bus3.if_gnt, bus3.d_stall, bus3.if_stall);
      end
    end
    @(negedge clk);
    checks++;
    if (bus3.d_gnt !== 1'b1 || bus3.if_stall !== 1'b1 || bus3.mem_we !== 1'b0 || cyc != c + 3) begin
      errors++; $display("FAIL lat3_load_gnt d_gnt=%b if_stall=%b we=%b cyc=%0d expected 1/1/0/%0d", bus3.d_gnt, bus3.if_stall, bus3.mem_we, cyc, c + 3);
    end
    q_d3.push_back('{c + 7, 32'hDEAD_BEEF});
    @(posedge clk);
    #1;
    bus3.d_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (bus3.if_gnt !== 1'b0 || bus3.if_stall !== 1'b1) begin
        errors++; $display("FAIL lat3_fetch_wait i=%0d if_gnt=%b if_stall=%b expected 0/1", i, bus3.if_gnt, bus3.if_stall);
      end
    end
    @(negedge clk);
    checks++;
    if (bus3.if_gnt !== 1'b1) begin errors++; $display("FAIL lat3_fetch_gnt if_gnt=%b expected 1", bus3.if_gnt); end
    q_if3.push_back('{c + 10, init_word(0)});
    @(posedge clk);
    #1;
    drive_idle();
    repeat (8) @(negedge clk);
    checks++;
    if (q_if3.size() != 0 || q_d3.size() != 0) begin errors++; $display("FAIL lat3_drain pending=%0d expected 0", q_if3.size() + q_d3.size()); end
  endtask

  task automatic test_reset_mid_access();
    @(posedge clk);
    #1;
    bus3.d_req = 1'b1; bus3.d_we = 1'b0; bus3.d_addr = 8'h08; bus3.d_func3 = F3_LW;
    @(negedge clk);
    checks++;
    if (bus3.d_gnt !== 1'b1) begin errors++; $display("FAIL rstmid_gnt d_gnt=%b expected 1", bus3.d_gnt); end
    @(posedge clk);
    #1;
    drive_idle();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus3.d_gnt !== 1'b0 || bus3.if_gnt !== 1'b0 || bus3.mem_en !== 1'b0) begin
      errors++; $display("FAIL rstmid_cycle d_gnt=%b if_gnt=%b mem_en=%b expected 0", bus3.d_gnt, bus3.if_gnt, bus3.mem_en);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus3.d_req = 1'b1; bus3.d_addr = 8'h0C; bus3.d_func3 = F3_LW;
    @(negedge clk);
    checks++;
    if (bus3.d_gnt !== 1'b1 || bus3.d_rvalid !== 1'b0 || bus3.d_rdata !== 32'h0 || bus3.if_rvalid !== 1'b0) begin
      errors++; $display("FAIL rstmid_after d_gnt=%b d_rvalid=%b d_rdata=%h expected 1/0/0", bus3.d_gnt, bus3.d_rvalid, bus3.d_rdata);
    end
    q_d3.push_back('{cyc + 4, init_word(3)});
    @(posedge clk);
    #1;
    drive_idle();
    repeat (8) @(negedge clk);
    checks++;
    if (q_d3.size() != 0) begin errors++; $display("FAIL rstmid_drain pending=%0d expected 0", q_d3.size()); end
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_collision();
    test_starvation();
    test_store_load_lat3();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
